my_axi4_lite_mst_bridge: RTL and testbench
==========================================

// Module: my_axi4_lite_mst_bridge
// PURPOSE
//   AXI4-Lite master: turns single-word commands from a simple valid/ready command port into AXI4-Lite
//   write/read transactions, and returns each result on a valid/ready response port.
//   Serves as the bus-side driver for register blocks such as my_axi4_lite_slv_template.
//   Exactly one outstanding transaction; the next command is accepted only after the response handshake.
// PARAMETERS
//   ADDR_BIT_WIDTH  4   AXI4-Lite address width; must equal if_m_axi4_lite.ADDR_BIT_WIDTH, else $error at elaboration
//   DATA_BIT_WIDTH  32  AXI4-Lite data width (32 only); must equal if_m_axi4_lite.DATA_BIT_WIDTH, else $error
// PORTS
//   i_clk           in   1        clock; the only clock
//   i_async_rst     in   1        reset, asynchronous, active-high
//   i_cmd_valid     in   1        command valid
//   o_cmd_ready     out  1        command ready; equals (state==IDLE)
//   i_cmd_wr        in   1        1=write, 0=read
//   i_cmd_addr      in   ADDR     byte address, forwarded unmodified
//   i_cmd_wdata     in   DATA     write data (ignored for reads)
//   i_cmd_wstrb     in   DATA/8   write byte strobes (ignored for reads)
//   o_rsp_valid     out  1        response valid
//   i_rsp_ready     in   1        response ready
//   o_rsp_wr        out  1        response belongs to a write
//   o_rsp_rdata     out  DATA     read data; 0 for writes
//   o_rsp_resp      out  2        BRESP/RRESP as returned (resp_t)
//   if_m_axi4_lite  mst  -        aix4_lite_if.mst_port, all five channels
// BEHAVIOUR
//   Reset: asserting i_async_rst immediately (no clock edge needed) forces state=IDLE and clears every output:
//     AWVALID, WVALID, BREADY, ARVALID, RREADY, o_rsp_valid = 0; addr/data/strb/rdata/resp regs = 0.
//     The in-flight transaction is abandoned, so the slave must also be reset.
//   Every AXI output is driven from a flop; there are no combinational in->out paths.
//   The only exception is o_cmd_ready, which is decoded from state.
//   FSM: IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP.
//   IDLE: on i_cmd_valid, capture addr/wdata/wstrb/wr.
//     If wr: go to WR_AW_W; next cycle AWVALID=WVALID=1.
//     Else: go to RD_AR; next cycle ARVALID=1.
//   WR_AW_W: AW and W complete independently, tracked by flags aw_done and w_done.
//     AWVALID drops the cycle after AWREADY&AWVALID; WVALID drops the cycle after WREADY&WVALID.
//     Both handshakes in the same cycle is legal. Payloads stay stable while a VALID is high.
//     Once both are done: go to WR_B with BREADY=1.
//   WR_B: on BVALID&BREADY, BREADY<=0 and capture BRESP into o_rsp_resp.
//     Set o_rsp_wr=1, o_rsp_rdata=0, o_rsp_valid=1, then go to RSP.
//   RD_AR: on ARVALID&ARREADY, ARVALID<=0, RREADY<=1, go to RD_R.
//   RD_R: on RVALID&RREADY, RREADY<=0 and capture RDATA/RRESP.
//     Set o_rsp_wr=0, o_rsp_valid=1, then go to RSP.
//   RSP: o_rsp_* held stable until i_rsp_ready; then o_rsp_valid<=0 and go to IDLE.
//     The earliest next-command acceptance is the cycle after the response handshake.
//   Latency, zero-wait slave: write is command accept -> AW/W valid +1 -> BREADY +1 -> rsp_valid +1 after BVALID.
//   Error responses (SLVERR/DECERR) are passed through unchanged; the FSM never waits on them.
//   There is no timeout: a slave that never responds stalls the block, which is legal per the AXI spec.
// STRUCTURE
//   Shared package my_axi4_lite_pkg holds:
//     typedef enum logic [1:0] resp_t {OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3};
//     localparam AXI4_LITE_DATA_BIT_WIDTH=32.
//   The state enum is local to the module.
//   No sub-module: a single FSM plus capture registers, about 200 lines.
// TESTING
//   Bench: DUT connected to my_axi4_lite_slv_template, plus a configurable-delay slave BFM for the stall and error cases.
//   1 write 0x0000_0004 data 0xDEAD_BEEF strb 0xF, then read 0x4
//     -> write rsp: wr=1, resp=OKAY
//     -> read rsp: rdata=0xDEAD_BEEF, resp=OKAY
//   2 write 0x4 data 0x0000_1234 strb 0x3, then read 0x4 -> rdata=0xDEAD_1234
//   3 BFM holds AWREADY low 3 cycles and gives WREADY immediately
//     -> WVALID is high exactly 1 cycle
//     -> AWVALID/AWADDR stay stable for 4 cycles
//     -> BREADY rises only after the AW handshake
//   4 BFM returns BRESP=SLVERR on the write and RRESP=DECERR on the read
//     -> o_rsp_resp=2 and 3 respectively; FSM returns to IDLE
//   5 i_rsp_ready held low 5 cycles after o_rsp_valid, with i_cmd_valid high throughout
//     -> o_rsp_* stable for 5 cycles, o_cmd_ready=0, no AXI VALID asserted
//   6 i_async_rst pulsed mid-cycle during RD_R
//     -> ARVALID/RREADY/o_rsp_valid go to 0 before the next edge, o_cmd_ready=1 after release

Source files
------------

// File: rtl/my_axi4_lite_pkg.sv
// Shared AXI4-Lite types and constants for the bridge and its bus interface.
package my_axi4_lite_pkg;

  localparam int unsigned AXI4_LITE_DATA_BIT_WIDTH = 32;

  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } resp_t;

endpackage

// File: rtl/my_axi4_lite_mst_bridge_if.sv
// AXI4-Lite five-channel bus bundle with master and slave views.
interface axi4_lite_if #(
  parameter int unsigned ADDR_BIT_WIDTH = 4,
  parameter int unsigned DATA_BIT_WIDTH = 32
);
  import my_axi4_lite_pkg::*;

  localparam int unsigned STRB_BIT_WIDTH = DATA_BIT_WIDTH / 8;

  logic                      awvalid;
  logic                      awready;
  logic [ADDR_BIT_WIDTH-1:0] awaddr;
  logic                      wvalid;
  logic                      wready;
  logic [DATA_BIT_WIDTH-1:0] wdata;
  logic [STRB_BIT_WIDTH-1:0] wstrb;
  logic                      bvalid;
  logic                      bready;
  resp_t                     bresp;
  logic                      arvalid;
  logic                      arready;
  logic [ADDR_BIT_WIDTH-1:0] araddr;
  logic                      rvalid;
  logic                      rready;
  logic [DATA_BIT_WIDTH-1:0] rdata;
  resp_t                     rresp;

  modport mst_port (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slv_port (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

endinterface

// File: rtl/my_axi4_lite_mst_bridge.sv
// AXI4-Lite master: one command in, one AXI transaction out, one response back.
// Single outstanding transaction; every AXI output comes straight from a flop.
module my_axi4_lite_mst_bridge
  import my_axi4_lite_pkg::*;
#(
  parameter int unsigned ADDR_BIT_WIDTH = 4,
  parameter int unsigned DATA_BIT_WIDTH = AXI4_LITE_DATA_BIT_WIDTH
) (
  input  logic                        i_clk,
  input  logic                        i_async_rst,
  input  logic                        i_cmd_valid,
  output logic                        o_cmd_ready,
  input  logic                        i_cmd_wr,
  input  logic [ADDR_BIT_WIDTH-1:0]   i_cmd_addr,
  input  logic [DATA_BIT_WIDTH-1:0]   i_cmd_wdata,
  input  logic [DATA_BIT_WIDTH/8-1:0] i_cmd_wstrb,
  output logic                        o_rsp_valid,
  input  logic                        i_rsp_ready,
  output logic                        o_rsp_wr,
  output logic [DATA_BIT_WIDTH-1:0]   o_rsp_rdata,
  output resp_t                       o_rsp_resp,
  axi4_lite_if.mst_port               if_m_axi4_lite
);

  localparam int unsigned STRB_BIT_WIDTH = DATA_BIT_WIDTH / 8;

  // Parameter consistency with the attached bus.
  if (ADDR_BIT_WIDTH != if_m_axi4_lite.ADDR_BIT_WIDTH) begin : g_addr_width_err
    $error("my_axi4_lite_mst_bridge: ADDR_BIT_WIDTH differs from interface");
  end
  if (DATA_BIT_WIDTH != if_m_axi4_lite.DATA_BIT_WIDTH) begin : g_data_width_err
    $error("my_axi4_lite_mst_bridge: DATA_BIT_WIDTH differs from interface");
  end
  if (DATA_BIT_WIDTH != AXI4_LITE_DATA_BIT_WIDTH) begin : g_data_width_32_err
    $error("my_axi4_lite_mst_bridge: only 32-bit data is supported");
  end

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_AW_W = 3'd1,
    WR_B    = 3'd2,
    RD_AR   = 3'd3,
    RD_R    = 3'd4,
    RSP     = 3'd5
  } state_t;

  state_t                    state_q,     state_d;
  logic                      awvalid_q,   awvalid_d;
  logic                      wvalid_q,    wvalid_d;
  logic                      bready_q,    bready_d;
  logic                      arvalid_q,   arvalid_d;
  logic                      rready_q,    rready_d;
  logic                      aw_done_q,   aw_done_d;
  logic                      w_done_q,    w_done_d;
  logic [ADDR_BIT_WIDTH-1:0] addr_q,      addr_d;
  logic [DATA_BIT_WIDTH-1:0] wdata_q,     wdata_d;
  logic [STRB_BIT_WIDTH-1:0] wstrb_q,     wstrb_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic                      rsp_wr_q,    rsp_wr_d;
  logic [DATA_BIT_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  resp_t                     rsp_resp_q,  rsp_resp_d;

  logic aw_fire;
  logic w_fire;

  assign aw_fire = awvalid_q & if_m_axi4_lite.awready;
  assign w_fire  = wvalid_q  & if_m_axi4_lite.wready;

  // Next-state and next-register decode; everything holds unless a handshake moves it.
  always_comb begin
    state_d     = state_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rsp_valid_d = rsp_valid_q;
    rsp_wr_d    = rsp_wr_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;

    case (state_q)
      IDLE: begin
        if (i_cmd_valid) begin
          addr_d  = i_cmd_addr;
          wdata_d = i_cmd_wdata;
          wstrb_d = i_cmd_wstrb;
          if (i_cmd_wr) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = WR_AW_W;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RD_AR;
          end
        end
      end
      WR_AW_W: begin
        // AW and W may complete in either order or together.
        if (aw_fire) awvalid_d = 1'b0;
        if (w_fire)  wvalid_d  = 1'b0;
        aw_done_d = aw_done_q | aw_fire;
        w_done_d  = w_done_q  | w_fire;
        if (aw_done_d && w_done_d) begin
          bready_d = 1'b1;
          state_d  = WR_B;
        end
      end
      WR_B: begin
        if (if_m_axi4_lite.bvalid && bready_q) begin
          bready_d    = 1'b0;
          rsp_resp_d  = if_m_axi4_lite.bresp;
          rsp_wr_d    = 1'b1;
          rsp_rdata_d = '0;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end
      end
      RD_AR: begin
        if (arvalid_q && if_m_axi4_lite.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_R;
        end
      end
      RD_R: begin
        if (if_m_axi4_lite.rvalid && rready_q) begin
          rready_d    = 1'b0;
          rsp_rdata_d = if_m_axi4_lite.rdata;
          rsp_resp_d  = if_m_axi4_lite.rresp;
          rsp_wr_d    = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end
      end
      RSP: begin
        if (i_rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and capture registers; reset abandons any in-flight transaction.
  always_ff @(posedge i_clk or posedge i_async_rst) begin
    if (i_async_rst) begin
      state_q     <= IDLE;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_wr_q    <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= OKAY;
    end else begin
      state_q     <= state_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_wr_q    <= rsp_wr_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  assign o_cmd_ready = (state_q == IDLE);
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_wr    = rsp_wr_q;
  assign o_rsp_rdata = rsp_rdata_q;
  assign o_rsp_resp  = rsp_resp_q;

  assign if_m_axi4_lite.awvalid = awvalid_q;
  assign if_m_axi4_lite.awaddr  = addr_q;
  assign if_m_axi4_lite.wvalid  = wvalid_q;
  assign if_m_axi4_lite.wdata   = wdata_q;
  assign if_m_axi4_lite.wstrb   = wstrb_q;
  assign if_m_axi4_lite.bready  = bready_q;
  assign if_m_axi4_lite.arvalid = arvalid_q;
  assign if_m_axi4_lite.araddr  = addr_q;
  assign if_m_axi4_lite.rready  = rready_q;

endmodule

// File: tb/tb_my_axi4_lite_mst_bridge.sv
// Bench for my_axi4_lite_mst_bridge: register-file slave BFM with programmable
// stalls/error responses, and a response scoreboard.
module tb_my_axi4_lite_mst_bridge;
  import my_axi4_lite_pkg::*;

  typedef struct packed {
    logic        wr;
    logic [31:0] rdata;
    logic [1:0]  resp;
  } rsp_t;

  logic        i_clk;
  logic        i_async_rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_wr;
  logic [3:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_wr;
  logic [31:0] rsp_rdata;
  resp_t       rsp_resp;

  int n_cmp = 0;
  int n_err = 0;
  rsp_t exp_q[$];
  logic [31:0] model_mem [4];

  // BFM configuration
  int    aw_dly = 0;
  int    w_dly  = 0;
  logic  r_hold = 1'b0;
  resp_t bresp_cfg = OKAY;
  resp_t rresp_cfg = OKAY;

  axi4_lite_if #(.ADDR_BIT_WIDTH(4), .DATA_BIT_WIDTH(32)) ifc ();

  my_axi4_lite_mst_bridge #(.ADDR_BIT_WIDTH(4), .DATA_BIT_WIDTH(32)) dut (
    .i_clk          (i_clk),
    .i_async_rst    (i_async_rst),
    .i_cmd_valid    (cmd_valid),
    .o_cmd_ready    (cmd_ready),
    .i_cmd_wr       (cmd_wr),
    .i_cmd_addr     (cmd_addr),
    .i_cmd_wdata    (cmd_wdata),
    .i_cmd_wstrb    (cmd_wstrb),
    .o_rsp_valid    (rsp_valid),
    .i_rsp_ready    (rsp_ready),
    .o_rsp_wr       (rsp_wr),
    .o_rsp_rdata    (rsp_rdata),
    .o_rsp_resp     (rsp_resp),
    .if_m_axi4_lite (ifc)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Slave BFM
  int          aw_cnt, w_cnt;
  logic        aw_got, w_got, r_pend;
  logic [3:0]  aw_addr_s;
  logic [31:0] w_data_s, r_data_s;
  logic [3:0]  w_strb_s;
  logic [31:0] bfm_mem [4];

  assign ifc.awready = ifc.awvalid && !aw_got && (aw_cnt >= aw_dly);
  assign ifc.wready  = ifc.wvalid && !w_got && (w_cnt >= w_dly);
  assign ifc.arready = ifc.arvalid && !r_pend && !ifc.rvalid;

  always_ff @(posedge i_clk or posedge i_async_rst) begin
    if (i_async_rst) begin
      aw_cnt <= 0; w_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0; r_pend <= 1'b0;
      aw_addr_s <= '0; w_data_s <= '0; w_strb_s <= '0; r_data_s <= '0;
      ifc.bvalid <= 1'b0; ifc.bresp <= OKAY;
      ifc.rvalid <= 1'b0; ifc.rresp <= OKAY; ifc.rdata <= '0;
    end else begin
      if (aw_got && w_got && !ifc.bvalid) begin
        ifc.bvalid <= 1'b1; ifc.bresp <= bresp_cfg; aw_got <= 1'b0; w_got <= 1'b0;
      end
      if (ifc.bvalid && ifc.bready) ifc.bvalid <= 1'b0;
      if (ifc.awvalid && !aw_got) begin
        if (ifc.awready) begin aw_got <= 1'b1; aw_addr_s <= ifc.awaddr; aw_cnt <= 0; end
        else aw_cnt <= aw_cnt + 1;
      end
      if (ifc.wvalid && !w_got) begin
        if (ifc.wready) begin w_got <= 1'b1; w_data_s <= ifc.wdata; w_strb_s <= ifc.wstrb; w_cnt <= 0; end
        else w_cnt <= w_cnt + 1;
      end
      if (ifc.arvalid && ifc.arready) begin r_pend <= 1'b1; r_data_s <= bfm_mem[ifc.araddr[3:2]]; end
      if (r_pend && !ifc.rvalid && !r_hold) begin
        ifc.rvalid <= 1'b1; ifc.rdata <= r_data_s; ifc.rresp <= rresp_cfg; r_pend <= 1'b0;
      end
      if (ifc.rvalid && ifc.rready) ifc.rvalid <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_async_rst && aw_got && w_got && !ifc.bvalid) begin
      for (int b = 0; b < 4; b++)
        if (w_strb_s[b]) bfm_mem[aw_addr_s[3:2]][8*b +: 8] <= w_data_s[8*b +: 8];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Issue one command (called at a negedge, returns at the negedge after acceptance).
  task automatic do_cmd(input logic wr, input logic [3:0] a, input logic [31:0] d,
                        input logic [3:0] s, input bit keep_valid, input bit expect_rsp);
    bit   ok;
    rsp_t e;
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (cmd_ready) begin ok = 1'b1; break; end
      @(negedge i_clk);
    end
    check("cmd_accept", 64'(ok), 64'(1));
    if (expect_rsp) begin
      if (wr) begin
        model_mem[a[3:2]] = merge(model_mem[a[3:2]], d, s);
        e = '{wr: 1'b1, rdata: 32'h0, resp: bresp_cfg};
      end else begin
        e = '{wr: 1'b0, rdata: model_mem[a[3:2]], resp: rresp_cfg};
      end
      exp_q.push_back(e);
    end
    @(negedge i_clk);
    if (!keep_valid) cmd_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0 && cmd_ready) begin ok = 1'b1; break; end
      @(negedge i_clk);
    end
    check(tag, 64'(ok), 64'(1));
  endtask

  // Scoreboard: compare each response at its handshake.
  initial begin
    rsp_t e;
    forever begin
      @(negedge i_clk);
      #1;
      if (!i_async_rst && rsp_valid && rsp_ready) begin
        check("rsp_expected", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("rsp", 64'({rsp_wr, rsp_rdata, rsp_resp}), 64'(e));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   wv_cyc, av_cyc, addr_bad;
    bit   aw_hs, bready_early, bready_seen, ok;
    rsp_t e;

    for (int i = 0; i < 4; i++) model_mem[i] = 32'h0;
    i_async_rst = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b1;
    #3;
    check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
    check("rst_axi_valids", 64'({ifc.awvalid, ifc.wvalid, ifc.bready, ifc.arvalid, ifc.rready}), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_rsp_regs", 64'({rsp_wr, rsp_rdata, rsp_resp}), 64'(0));
    check("rst_axi_payload", 64'({ifc.awaddr, ifc.wdata, ifc.wstrb}), 64'(0));
    @(negedge i_clk);
    i_async_rst = 1'b0;
    @(negedge i_clk);

    // 1: full write then readback
    do_cmd(1'b1, 4'h4, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b1);
    do_cmd(1'b0, 4'h4, 32'h0, 4'h0, 1'b0, 1'b1);
    wait_drain("t1_drain");

    // 2: partial-strobe write
    do_cmd(1'b1, 4'h4, 32'h0000_1234, 4'h3, 1'b0, 1'b1);
    do_cmd(1'b0, 4'h4, 32'h0, 4'h0, 1'b0, 1'b1);
    wait_drain("t2_drain");
    check("t2_model", 64'(model_mem[1]), 64'(32'hDEAD_1234));

    // 3: AW stalled 3 cycles, W accepted immediately
    aw_dly = 3;
    do_cmd(1'b1, 4'h8, 32'h5555_AAAA, 4'hF, 1'b0, 1'b1);
    wv_cyc = 0; av_cyc = 0; addr_bad = 0;
    aw_hs = 1'b0; bready_early = 1'b0; bready_seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (rsp_valid) break;
      if (ifc.wvalid) wv_cyc++;
      if (ifc.awvalid) begin
        av_cyc++;
        if (ifc.awaddr !== 4'h8) addr_bad++;
      end
      if (ifc.bready) begin
        bready_seen = 1'b1;
        if (!aw_hs) bready_early = 1'b1;
      end
      if (ifc.awvalid && ifc.awready) aw_hs = 1'b1;
      @(negedge i_clk);
    end
    check("t3_wvalid_cycles", 64'(wv_cyc), 64'(1));
    check("t3_awvalid_cycles", 64'(av_cyc), 64'(4));
    check("t3_awaddr_stable", 64'(addr_bad), 64'(0));
    check("t3_bready_early", 64'(bready_early), 64'(0));
    check("t3_bready_seen", 64'(bready_seen), 64'(1));
    wait_drain("t3_drain");
    aw_dly = 0;

    // 4: error responses pass through
    bresp_cfg = SLVERR; rresp_cfg = DECERR;
    do_cmd(1'b1, 4'hC, 32'h0BAD_F00D, 4'hF, 1'b0, 1'b1);
    do_cmd(1'b0, 4'h8, 32'h0, 4'h0, 1'b0, 1'b1);
    wait_drain("t4_drain");
    check("t4_idle", 64'(cmd_ready), 64'(1));
    bresp_cfg = OKAY; rresp_cfg = OKAY;

    // 5: response back-pressure with a new command waiting
    rsp_ready = 1'b0;
    do_cmd(1'b0, 4'h4, 32'h0, 4'h0, 1'b1, 1'b1);
    e = exp_q[0];
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (rsp_valid) begin ok = 1'b1; break; end
      @(negedge i_clk);
    end
    check("t5_rsp_valid_seen", 64'(ok), 64'(1));
    for (int k = 0; k < 5; k++) begin
      check("t5_rsp_hold", 64'({rsp_valid, rsp_wr, rsp_rdata, rsp_resp}), 64'({1'b1, e}));
      check("t5_cmd_ready", 64'(cmd_ready), 64'(0));
      check("t5_axi_idle", 64'({ifc.awvalid, ifc.wvalid, ifc.arvalid}), 64'(0));
      @(negedge i_clk);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_drain("t5_drain");

    // 6: asynchronous reset while waiting for R
    r_hold = 1'b1;
    do_cmd(1'b0, 4'h4, 32'h0, 4'h0, 1'b0, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (ifc.rready) begin ok = 1'b1; break; end
      @(negedge i_clk);
    end
    check("t6_in_rd_r", 64'(ok), 64'(1));
    #2 i_async_rst = 1'b1;
    #1;
    check("t6_rst_axi", 64'({ifc.arvalid, ifc.rready, rsp_valid}), 64'(0));
    check("t6_rst_cmd_ready", 64'(cmd_ready), 64'(1));
    #1 i_async_rst = 1'b0;
    r_hold = 1'b0;
    @(negedge i_clk);
    check("t6_cmd_ready_after", 64'(cmd_ready), 64'(1));
    check("t6_no_rsp", 64'(rsp_valid), 64'(0));

    // Post-reset traffic still works
    do_cmd(1'b1, 4'h0, 32'hCAFE_0001, 4'hF, 1'b0, 1'b1);
    do_cmd(1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 1'b1);
    do_cmd(1'b0, 4'hC, 32'h0, 4'h0, 1'b0, 1'b1);
    wait_drain("t7_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
